ps_bus_arbiter: RTL and testbench
=================================

// Module: ps_bus_arbiter
// PURPOSE
//  Round-robin arbiter sharing the single ps_if register-file port of rf_node between NUM_REQ masters
//  (req 0 = AXI-lite adapter, others = on-chip sequencers). Sits between the requesters and rf_node.
//  Exactly one transaction is outstanding downstream at a time; each completion is returned to its issuer.
// PARAMETERS
//  NUM_REQ         2     number of requesters, >=2
//  ADDR_WIDTH      4     register address width
//  DATA_WIDTH      32    register data width
//  TIMEOUT_CYCLES  256   read-response watchdog limit (used only with PS_ARB_TIMEOUT_EN)
// PORTS
//  clk        in   1                    single clock; all logic is rising-edge
//  rst_n      in   1                    asynchronous, active-low reset
//  req_valid  in   NUM_REQ              per-requester request pending
//  req_we     in   NUM_REQ              1=write, 0=read
//  req_addr   in   NUM_REQ*ADDR_WIDTH   flattened, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//  req_wdata  in   NUM_REQ*DATA_WIDTH   flattened write data
//  req_ready  out  NUM_REQ              one-hot, 1-cycle pulse: request captured
//  rsp_valid  out  NUM_REQ              one-hot, 1-cycle pulse: transaction complete
//  rsp_rdata  out  DATA_WIDTH           read data, valid with rsp_valid (0 for writes)
//  rsp_err    out  1                    error flag, valid with rsp_valid
//  ps_req     out  1                    downstream request
//  ps_we      out  1                    downstream write enable
//  ps_addr    out  ADDR_WIDTH           downstream address
//  ps_wdata   out  DATA_WIDTH           downstream write data
//  ps_ready   in   1                    downstream accepts (ps_req & ps_ready = handshake)
//  ps_rvalid  in   1                    downstream read data valid
//  ps_rdata   in   DATA_WIDTH           downstream read data
// BEHAVIOUR
//  - Reset: state=IDLE, rr pointer=0, all outputs 0. Async reset mid-transaction abandons it; no rsp issued.
//  - FSM IDLE -> ISSUE -> (write) RESP | (read) WAIT_RD -> RESP -> IDLE.
//  - IDLE: if any req_valid, pick first set bit searching from pointer upward with wrap-around (mod NUM_REQ);
//    pulse req_ready[g] that cycle (T), register g/we/addr/wdata, go ISSUE. Requester drops or reloads
//    req_valid after its req_ready; a still-high req_valid is treated as a new request.
//  - ISSUE: ps_req=1 from T+1 with registered fields held stable until ps_ready. On handshake: write -> RESP;
//    read -> WAIT_RD, or directly RESP capturing ps_rdata if ps_rvalid is high in the same cycle.
//  - WAIT_RD: hold until ps_rvalid; capture ps_rdata; go RESP. ps_rvalid outside ISSUE/WAIT_RD is ignored.
//  - RESP: rsp_valid[g]=1 for exactly one cycle, rsp_rdata=captured data (0 for writes), rsp_err=0;
//    pointer <= (g+1) mod NUM_REQ; go IDLE. Responses have no backpressure.
//  - Min latency: write req_ready(T) -> ps_req(T+1) -> rsp_valid(T+2) with ps_ready=1; next grant at T+3.
//  - Fairness: any continuously asserting requester is granted within NUM_REQ transactions.
// CONFIGURATION
//  PS_ARB_TIMEOUT_EN defined: counter cleared on entry to WAIT_RD; if it reaches TIMEOUT_CYCLES without
//    ps_rvalid, go RESP with rsp_err=1, rsp_rdata={DATA_WIDTH/32{32'hDEAD_BEEF}}; late ps_rvalid ignored.
//  Not defined: no counter, WAIT_RD waits indefinitely, rsp_err tied 0.
// STRUCTURE
//  ps_arb_pkg: state enum (IDLE, ISSUE, WAIT_RD, RESP), ERR_RDATA constant.
//  Sub-module rr_arbiter (combinational priority pick from req vector + pointer -> one-hot grant + index);
//  ps_bus_arbiter holds FSM, capture registers, pointer, optional watchdog.
// TESTING
//  1 Single read req0 addr 4'h3, ps_rdata 32'h1234_5678 after 2-cycle ps_rvalid delay -> rsp_valid=2'b01, rdata match.
//  2 req0,req1 both held high for 4 writes -> grants 0,1,0,1; ps_addr order matches; no starvation.
//  3 Write with ps_ready low 5 cycles -> ps_req/addr/wdata stable all 5 cycles, single rsp_valid after handshake.
//  4 Read with ps_ready & ps_rvalid same cycle -> rsp_valid next cycle, WAIT_RD skipped.
//  5 rst_n low during WAIT_RD -> all outputs 0 immediately, no rsp_valid afterwards, next grant uses pointer 0.
//  6 PS_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, ps_rvalid never -> rsp_err=1, rdata 32'hDEAD_BEEF, arbiter resumes.

Source files
------------

// File: rtl/ps_bus_arbiter_pkg.sv
// Shared types for the ps_if bus arbiter.
// State encoding and watchdog error data.
package ps_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RD,
    RESP
  } state_t;

  localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/ps_bus_arbiter_if.sv
// Requester and downstream ps_if bundle.
// slave = arbiter view, master = driver view.
interface ps_bus_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_we;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_rdata;
  logic                          rsp_err;
  logic                          ps_req;
  logic                          ps_we;
  logic [ADDR_WIDTH-1:0]         ps_addr;
  logic [DATA_WIDTH-1:0]         ps_wdata;
  logic                          ps_ready;
  logic                          ps_rvalid;
  logic [DATA_WIDTH-1:0]         ps_rdata;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    input  ps_ready, ps_rvalid, ps_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output ps_req, ps_we, ps_addr, ps_wdata
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    output ps_ready, ps_rvalid, ps_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  ps_req, ps_we, ps_addr, ps_wdata
  );
endinterface

// File: rtl/ps_bus_arbiter_rr_arbiter.sv
// Round-robin pick: first request at or above ptr,
// wrapping modulo NUM_REQ. Purely combinational.
module ps_bus_arbiter_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      idx,
  output logic               any
);
  logic          found;
  logic [IW-1:0] c;

  // scan from ptr upward, take the first set bit
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    c     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      c = IW'((int'(ptr) + i) % NUM_REQ);
      if (!found && req[c]) begin
        found  = 1'b1;
        gnt[c] = 1'b1;
        idx    = c;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/ps_bus_arbiter.sv
// Round-robin arbiter for the single rf_node ps_if port.
// Optional read watchdog: define PS_ARB_TIMEOUT_EN.
module ps_bus_arbiter
  import ps_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
`ifdef PS_ARB_TIMEOUT_EN
  ,parameter int TIMEOUT_CYCLES = 256
`endif
) (
  input logic             clk,
  input logic             rst_n,
  ps_bus_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);

  state_t                state, state_d;
  logic [IW-1:0]         ptr, g, pick;
  logic [NUM_REQ-1:0]    gnt;
  logic                  any;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
  logic                  we_sel;
  logic [ADDR_WIDTH-1:0] addr_sel;
  logic [DATA_WIDTH-1:0] wdata_sel;
  logic                  cap_req, cap_rd, cap_wr;
  logic                  expired;

  ps_bus_arbiter_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req (bus.req_valid),
    .ptr (ptr),
    .gnt (gnt),
    .idx (pick),
    .any (any)
  );

  // select the winning requester's fields
  always_comb begin
    we_sel    = 1'b0;
    addr_sel  = '0;
    wdata_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        we_sel    = bus.req_we[i];
        addr_sel  = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        wdata_sel = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

`ifdef PS_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmr;
  logic          err_q;

  assign expired = (tmr == TW'(TIMEOUT_CYCLES - 1));

  // watchdog counts WAIT_RD cycles, idle at zero elsewhere
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmr <= '0;
    else if (state != WAIT_RD) tmr <= '0;
    else tmr <= tmr + 1'b1;
  end
`else
  assign expired = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  end

  // next state and bus outputs
  always_comb begin
    state_d       = state;
    cap_req       = 1'b0;
    cap_rd        = 1'b0;
    cap_wr        = 1'b0;
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    bus.rsp_rdata = '0;
    bus.rsp_err   = 1'b0;
    bus.ps_req    = (state == ISSUE);
    bus.ps_we     = we_q;
    bus.ps_addr   = addr_q;
    bus.ps_wdata  = wdata_q;
    unique case (state)
      IDLE: begin
        if (rst_n) bus.req_ready = gnt;
        if (any) begin
          state_d = ISSUE;
          cap_req = 1'b1;
        end
      end
      ISSUE: begin
        if (bus.ps_ready) begin
          if (we_q) begin
            state_d = RESP;
            cap_wr  = 1'b1;
          end else if (bus.ps_rvalid) begin
            state_d = RESP;
            cap_rd  = 1'b1;
          end else begin
            state_d = WAIT_RD;
          end
        end
      end
      WAIT_RD: begin
        if (bus.ps_rvalid) begin
          state_d = RESP;
          cap_rd  = 1'b1;
        end else if (expired) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
        for (int i = 0; i < NUM_REQ; i++)
          bus.rsp_valid[i] = (g == IW'(i));
        bus.rsp_rdata = rdata_q;
`ifdef PS_ARB_TIMEOUT_EN
        bus.rsp_err = err_q;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // capture registers and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr     <= '0;
      g       <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef PS_ARB_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
    end else begin
      if (cap_req) begin
        g       <= pick;
        we_q    <= we_sel;
        addr_q  <= addr_sel;
        wdata_q <= wdata_sel;
      end
      if (cap_wr) rdata_q <= '0;
      if (cap_rd) rdata_q <= bus.ps_rdata;
`ifdef PS_ARB_TIMEOUT_EN
      if (cap_req) err_q <= 1'b0;
      if (state == WAIT_RD && !bus.ps_rvalid && expired) begin
        rdata_q <= {(DATA_WIDTH/32){ERR_RDATA}};
        err_q   <= 1'b1;
      end
`endif
      if (state == RESP)
        ptr <= (g == IW'(NUM_REQ - 1)) ? '0 : g + 1'b1;
    end
  end

endmodule

// File: tb/tb_ps_bus_arbiter.sv
// Directed bench for ps_bus_arbiter.
// Define PS_ARB_TIMEOUT_EN to add the watchdog case.
module tb_ps_bus_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  ps_bus_arbiter_if #(.NUM_REQ(2), .ADDR_WIDTH(4), .DATA_WIDTH(32)) bus ();

  ps_bus_arbiter #(
    .NUM_REQ(2),
    .ADDR_WIDTH(4),
    .DATA_WIDTH(32)
`ifdef PS_ARB_TIMEOUT_EN
    ,.TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.ps_ready  = 1'b0;
    bus.ps_rvalid = 1'b0;
    bus.ps_rdata  = '0;

    // reset state
    adv(); adv();
    smp();
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_rsp", bus.rsp_valid, 0);
    chk("rst_psreq", bus.ps_req, 0);
    chk("rst_err", bus.rsp_err, 0);
    adv();
    rst_n = 1'b1;

    // both requesters hold four writes: grants 0,1,0,1
    adv();
    bus.req_valid = 2'b11;
    bus.req_we    = 2'b11;
    bus.req_addr  = {4'h5, 4'hA};
    bus.req_wdata = {32'h5555_0001, 32'hAAAA_0000};
    bus.ps_ready  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      smp();
      chk("rr_ready", bus.req_ready, (k % 2) ? 2'b10 : 2'b01);
      adv();
      smp();
      chk("rr_psreq", bus.ps_req, 1);
      chk("rr_addr", bus.ps_addr, (k % 2) ? 4'h5 : 4'hA);
      chk("rr_wdata", bus.ps_wdata,
          (k % 2) ? 32'h5555_0001 : 32'hAAAA_0000);
      adv();
      smp();
      chk("rr_rsp", bus.rsp_valid, (k % 2) ? 2'b10 : 2'b01);
      chk("rr_rdata", bus.rsp_rdata, 0);
      adv();
    end
    bus.req_valid = '0;
    bus.ps_ready  = 1'b0;

    // single read from req0, data two cycles after handshake
    adv();
    bus.req_valid = 2'b01;
    bus.req_we    = 2'b00;
    bus.req_addr  = {4'h0, 4'h3};
    smp();
    chk("rd_ready", bus.req_ready, 2'b01);
    adv();
    bus.req_valid = '0;
    bus.ps_ready  = 1'b1;
    smp();
    chk("rd_psreq", bus.ps_req, 1);
    chk("rd_addr", bus.ps_addr, 4'h3);
    chk("rd_we", bus.ps_we, 0);
    adv();
    bus.ps_ready = 1'b0;
    smp();
    chk("rd_wait1", bus.rsp_valid, 0);
    chk("rd_wait_psreq", bus.ps_req, 0);
    adv();
    smp();
    chk("rd_wait2", bus.rsp_valid, 0);
    adv();
    bus.ps_rvalid = 1'b1;
    bus.ps_rdata  = 32'h1234_5678;
    smp();
    chk("rd_wait3", bus.rsp_valid, 0);
    adv();
    bus.ps_rvalid = 1'b0;
    bus.ps_rdata  = '0;
    smp();
    chk("rd_rsp", bus.rsp_valid, 2'b01);
    chk("rd_rdata", bus.rsp_rdata, 32'h1234_5678);
    chk("rd_err", bus.rsp_err, 0);
    adv();
    smp();
    chk("rd_rsp_end", bus.rsp_valid, 0);

    // write with ps_ready low for five cycles (pointer now 1)
    adv();
    bus.req_valid = 2'b10;
    bus.req_we    = 2'b10;
    bus.req_addr  = {4'h7, 4'h0};
    bus.req_wdata = {32'hCAFE_F00D, 32'h0};
    smp();
    chk("st_ready", bus.req_ready, 2'b10);
    adv();
    bus.req_valid = '0;
    for (int i = 0; i < 5; i++) begin
      smp();
      chk("st_psreq", bus.ps_req, 1);
      chk("st_addr", bus.ps_addr, 4'h7);
      chk("st_wdata", bus.ps_wdata, 32'hCAFE_F00D);
      chk("st_norsp", bus.rsp_valid, 0);
      adv();
    end
    bus.ps_ready = 1'b1;
    smp();
    chk("st_hs", bus.ps_req, 1);
    adv();
    bus.ps_ready = 1'b0;
    smp();
    chk("st_rsp", bus.rsp_valid, 2'b10);
    adv();
    smp();
    chk("st_rsp_end", bus.rsp_valid, 0);

    // read with ps_ready and ps_rvalid together
    adv();
    bus.req_valid = 2'b01;
    bus.req_we    = 2'b00;
    bus.req_addr  = {4'h0, 4'h9};
    smp();
    chk("fr_ready", bus.req_ready, 2'b01);
    adv();
    bus.req_valid = '0;
    bus.ps_ready  = 1'b1;
    bus.ps_rvalid = 1'b1;
    bus.ps_rdata  = 32'h0BAD_F00D;
    smp();
    chk("fr_psreq", bus.ps_req, 1);
    adv();
    bus.ps_ready  = 1'b0;
    bus.ps_rvalid = 1'b0;
    smp();
    chk("fr_rsp", bus.rsp_valid, 2'b01);
    chk("fr_rdata", bus.rsp_rdata, 32'h0BAD_F00D);
    adv();
    smp();
    chk("fr_idle_rsp", bus.rsp_valid, 0);
    chk("fr_idle_psreq", bus.ps_req, 0);

    // reset during WAIT_RD (pointer now 1)
    adv();
    bus.req_valid = 2'b10;
    bus.req_we    = 2'b00;
    bus.req_addr  = {4'hE, 4'h0};
    smp();
    chk("ar_ready", bus.req_ready, 2'b10);
    adv();
    bus.req_valid = '0;
    bus.ps_ready  = 1'b1;
    smp();
    chk("ar_psreq", bus.ps_req, 1);
    adv();
    bus.ps_ready = 1'b0;
    smp();
    rst_n = 1'b0;
    #1;
    chk("ar_psreq0", bus.ps_req, 0);
    chk("ar_addr0", bus.ps_addr, 0);
    chk("ar_we0", bus.ps_we, 0);
    chk("ar_wdata0", bus.ps_wdata, 0);
    chk("ar_rsp0", bus.rsp_valid, 0);
    chk("ar_rdata0", bus.rsp_rdata, 0);
    chk("ar_ready0", bus.req_ready, 0);
    adv();
    adv();
    rst_n = 1'b1;
    bus.ps_rvalid = 1'b1;
    bus.ps_rdata  = 32'hFFFF_FFFF;
    smp();
    chk("ar_stray", bus.rsp_valid, 0);
    adv();
    bus.ps_rvalid = 1'b0;
    bus.req_valid = 2'b11;
    bus.req_we    = 2'b11;
    bus.req_addr  = {4'h1, 4'h2};
    bus.req_wdata = {32'h1111_1111, 32'h2222_2222};
    smp();
    chk("ar_ptr0", bus.req_ready, 2'b01);
    chk("ar_stray2", bus.rsp_valid, 0);
    adv();
    bus.req_valid = '0;
    bus.ps_ready  = 1'b1;
    smp();
    chk("ar_addr", bus.ps_addr, 4'h2);
    adv();
    bus.ps_ready = 1'b0;
    smp();
    chk("ar_rsp", bus.rsp_valid, 2'b01);
    adv();

`ifdef PS_ARB_TIMEOUT_EN
    // read never answered: watchdog after 8 cycles (pointer now 1)
    bus.req_valid = 2'b10;
    bus.req_we    = 2'b00;
    bus.req_addr  = {4'h2, 4'h0};
    smp();
    chk("to_ready", bus.req_ready, 2'b10);
    adv();
    bus.req_valid = '0;
    bus.ps_ready  = 1'b1;
    smp();
    chk("to_psreq", bus.ps_req, 1);
    adv();
    bus.ps_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      smp();
      chk("to_wait", bus.rsp_valid, 0);
      adv();
    end
    smp();
    chk("to_rsp", bus.rsp_valid, 2'b10);
    chk("to_err", bus.rsp_err, 1);
    chk("to_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);
    adv();
    bus.ps_rvalid = 1'b1;
    smp();
    chk("to_late", bus.rsp_valid, 0);
    adv();
    bus.ps_rvalid = 1'b0;
    bus.req_valid = 2'b01;
    bus.req_we    = 2'b01;
    smp();
    chk("to_resume", bus.req_ready, 2'b01);
    adv();
    bus.req_valid = '0;
    bus.ps_ready  = 1'b1;
    adv();
    bus.ps_ready = 1'b0;
    smp();
    chk("to_resume_rsp", bus.rsp_valid, 2'b01);
    chk("to_resume_err", bus.rsp_err, 0);
    adv();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
